// File: rtl/a1339_spi_responder_if.sv
// SPI link between the A1339 sensor controller (master) and a sensor or
// its emulation (slave); mode 3, 20-bit frames.
interface a1339_spi_responder_if;
    logic sck_i;
    logic ss_n_i;
    logic mosi_i;
    logic miso_o;
    logic miso_oe;

    modport master (
        output sck_i,
        output ss_n_i,
        output mosi_i,
        input  miso_o,
        input  miso_oe
    );

    modport slave (
        input  sck_i,
        input  ss_n_i,
        input  mosi_i,
        output miso_o,
        output miso_oe
    );
endinterface

// File: rtl/a1339_spi_responder.sv
// A1339 angle sensor emulation: SPI slave answering angle/turns reads with a
// 12-bit value plus 4-bit CRC, one frame after the command (interleaved).
module a1339_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ANGLE_ADDR  = 8'h00,
    parameter logic [7:0] TURNS_ADDR  = 8'hC0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    a1339_spi_responder_if.slave    spi,
    input  logic [11:0]             angle_value,
    input  logic [11:0]             turns_value,
    input  logic                    crc_error_inject,
    output logic                    frame_done,
    output logic                    frame_error,
    output logic [19:0]             last_command
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    // Sensor CRC: init 1111, MSB first, feedback into c1 and c0.
    function automatic logic [3:0] crc4_f(input logic [15:0] data);
        logic [3:0] c;
        logic       inv;
        c = 4'hF;
        for (int i = 15; i >= 0; i--) begin
            inv = data[i] ^ c[3];
            c   = {c[2], c[1], c[0] ^ inv, inv};
        end
        return c;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] ss_n_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_q_r;
    logic                   ss_n_q_r;

    logic                   sck_s;
    logic                   ss_n_s;
    logic                   mosi_s;
    logic                   sck_rise_s;
    logic                   sck_fall_s;
    logic                   ss_fall_s;
    logic                   ss_rise_s;

    state_t                 state_r;
    logic [19:0]            tx_r;
    logic [19:0]            rx_r;
    logic [4:0]             bit_cnt_r;
    logic [19:0]            resp_r;
    logic                   miso_r;
    logic                   miso_oe_r;
    logic                   frame_done_r;
    logic                   frame_error_r;
    logic [19:0]            last_command_r;

    logic [15:0]            resp_field_s;
    logic [3:0]             resp_crc_s;

    // Synchronizers for the asynchronous SPI pins; idle levels preset on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_r  <= {SYNC_STAGES{1'b1}};
            ss_n_sync_r <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_q_r     <= 1'b1;
            ss_n_q_r    <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi.sck_i};
            ss_n_sync_r <= {ss_n_sync_r[SYNC_STAGES-2:0], spi.ss_n_i};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi.mosi_i};
            sck_q_r     <= sck_s;
            ss_n_q_r    <= ss_n_s;
        end
    end

    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign ss_n_s     = ss_n_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_q_r;
    assign sck_fall_s = ~sck_s & sck_q_r;
    assign ss_fall_s  = ~ss_n_s & ss_n_q_r;
    assign ss_rise_s  = ss_n_s & ~ss_n_q_r;

    // Decode the received command into the next response field and its CRC.
    always_comb begin
        resp_field_s = 16'h0000;
        if (rx_r[19:16] == 4'h2 && rx_r[15:8] == ANGLE_ADDR) begin
            resp_field_s = {4'h0, angle_value};
        end else if (rx_r[19:16] == 4'h2 && rx_r[15:8] == TURNS_ADDR) begin
            resp_field_s = {4'h0, turns_value};
        end else begin
            resp_field_s = 16'h0000;
        end
        resp_crc_s = crc4_f(resp_field_s);
        if (crc_error_inject) begin
            resp_crc_s = ~resp_crc_s;
        end else begin
            resp_crc_s = resp_crc_s;
        end
    end

    // Frame state machine: shift out the stored response, shift in the command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            tx_r           <= 20'h00000;
            rx_r           <= 20'h00000;
            bit_cnt_r      <= 5'd0;
            resp_r         <= 20'h0000D;
            miso_r         <= 1'b1;
            miso_oe_r      <= 1'b0;
            frame_done_r   <= 1'b0;
            frame_error_r  <= 1'b0;
            last_command_r <= 20'h00000;
        end else begin
            frame_done_r  <= 1'b0;
            frame_error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ss_fall_s) begin
                        tx_r      <= resp_r;
                        bit_cnt_r <= 5'd0;
                        miso_oe_r <= 1'b1;
                        state_r   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (ss_rise_s) begin
                        miso_oe_r <= 1'b0;
                        miso_r    <= 1'b1;
                        state_r   <= COMPLETE;
                    end else begin
                        if (sck_fall_s) begin
                            miso_r <= tx_r[19];
                            tx_r   <= {tx_r[18:0], 1'b0};
                        end
                        if (sck_rise_s) begin
                            rx_r <= {rx_r[18:0], mosi_s};
                            if (bit_cnt_r != 5'd31) begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                end
                COMPLETE: begin
                    // Short or overlong frames leave the pending response intact.
                    if (bit_cnt_r == 5'd20) begin
                        last_command_r <= rx_r;
                        resp_r         <= {resp_field_s, resp_crc_s};
                        frame_done_r   <= 1'b1;
                    end else begin
                        frame_error_r  <= 1'b1;
                    end
                    miso_oe_r <= 1'b0;
                    miso_r    <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    miso_oe_r <= 1'b0;
                    miso_r    <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign spi.miso_o   = miso_r;
    assign spi.miso_oe  = miso_oe_r;
    assign frame_done   = frame_done_r;
    assign frame_error  = frame_error_r;
    assign last_command = last_command_r;

endmodule

// File: doc/a1339_spi_responder.md
Name: a1339_spi_responder

Overview:
- Emulates one A1339 angle sensor as the SPI slave end of the 20-bit sensor link.
- Decodes read commands for the angle and turns registers and returns 12-bit values with the 4-bit CRC the sensor controller checks.
- Responses are interleaved: the reply to command N is shifted out during frame N+1, matching the real sensor.
- Used for on-chip loopback/self-test of the sensor controller and in simulation benches; all SPI inputs are asynchronous to clock.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sck_i/ss_n_i/mosi_i (min 2).
- ANGLE_ADDR, 8'h00, address byte selecting the angle register.
- TURNS_ADDR, 8'hC0, address byte selecting the turns register.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- sck_i  input  1  SPI clock, mode 3 (idle high).
- ss_n_i  input  1  slave select, active low.
- mosi_i  input  1  command data, MSB first.
- miso_o  output  1  response data, MSB first.
- miso_oe  output  1  high while selected; board tristates miso when low.
- angle_value  input  12  current angle, sampled at command completion.
- turns_value  input  12  current turn count, sampled at command completion.
- crc_error_inject  input  1  when high at command completion, the next response carries an inverted CRC.
- frame_done  output  1  one-cycle pulse per valid 20-bit frame.
- frame_error  output  1  one-cycle pulse when ss_n rises with bit count != 20.
- last_command  output  20  last valid command frame received.

Behaviour:
- Reset (asynchronous, reset_n=0) values:
  - miso_o=1, miso_oe=0, frame_done=0, frame_error=0, last_command=0.
  - Response register = 20'h0000D (data 0, CRC of 0x0000). State IDLE.
- Input handling:
  - All three SPI inputs pass through SYNC_STAGES flops, then a one-flop edge detect.
  - Legal SCK half-period is >= SYNC_STAGES+2 clock cycles.
- Frame format, both directions: [19:4] 16-bit field, [3:0] CRC.
- Command decode, on [19:4] of the command frame:
  - [19:16]=4'h2 marks a read.
  - [15:8] is the address.
  - [7:4] is ignored.
- Response field: {4'h0, value[11:0]}.
- CRC over the 16-bit field, MSB first:
  - Init c3..c0=1111.
  - Per bit: inv=bit^c3; c3=c2; c2=c1; c1=c0^inv; c0=inv.
  - CRC = {c3,c2,c1,c0}.
  - Computed serially or combinationally; must be ready before the next ss_n fall.
- State machine:
  - IDLE: on synced ss_n falling edge: load tx shift register from response register, bit_cnt=0, miso_oe=1 -> ACTIVE.
  - ACTIVE, SCK falling edge: miso_o <= tx[19]; tx <= tx<<1. The first falling edge presents bit 19.
  - ACTIVE, SCK rising edge: rx <= {rx[18:0], mosi}; bit_cnt++ (saturate at 31).
  - ACTIVE, ss_n rising edge -> COMPLETE.
  - COMPLETE, bit_cnt==20:
    - last_command <= rx; frame_done pulse.
    - Read of ANGLE_ADDR -> response = angle_value. Read of TURNS_ADDR -> response = turns_value.
    - Any other command -> response field 0x0000.
    - CRC appended; inverted if crc_error_inject=1.
    - -> IDLE.
  - COMPLETE, bit_cnt!=20: frame_error pulse; response register and last_command unchanged -> IDLE.
  - In COMPLETE, miso_oe=0 and miso_o=1.
- Edge cases:
  - SCK edges while ss_n high are ignored.
  - More than 20 clocks: bit_cnt > 20 is a framing error.
  - ss_n falling in the same cycle as frame_done is impossible: COMPLETE lasts one cycle, and the synchronizer guarantees a >=1 cycle gap.
  - reset_n asserted mid-frame aborts immediately to reset values; the frame in progress produces no pulse.

Test Plan:
- Reset, then one frame with command 20'h20009 -> miso shifts 20'h0000D; frame_done=1 for 1 cycle; last_command=20'h20009.
- angle_value=12'h123, send 20'h20009, then 20'h20009 -> second frame returns [19:4]=16'h0123 and [3:0] equal to the model CRC; the sensor controller's CRC check passes.
- turns_value=12'h005, send 20'h2C001, then 20'h20009 -> second response field = 16'h0005; angle and turns alternate correctly over 8 interleaved frames.
- ss_n low for 12 SCK cycles only -> frame_error pulse, no frame_done; next frame returns the previous response unchanged.
- crc_error_inject=1 during command completion -> next response CRC = ~model CRC; controller flags data invalid (LED[2]=0).
- reset_n pulled low after bit 10 of a frame -> miso_oe=0, no pulses; next full frame returns 20'h0000D.
